axis_tx_if: RTL and testbench
=============================

# axis_tx_if

CPU-to-AXI-stream bridge: the transmit-direction companion of the switch-reader stream interface in the SoC top. The HF-RISCV core writes bytes into a memory-mapped register window; the block buffers them in a small FIFO and drives them out as an 8-bit AXI-stream master. Typical sinks are a keyboard/LED/display stream peripheral. It sits beside the existing stream interface, and its `data_access_o` and `data_o` feed the same external-peripheral read mux.

## Interface
- `BASE_TAG`, default 8'hE2: value that `addr_i[31:24]` must equal to select the block.
- `DEPTH`, default 8: FIFO entries; power of two, 2..256.
- `clk_i` in 1: system clock (50 MHz `clock` domain).
- `rst_i` in 1: reset. **One clock; reset is synchronous and active-high.**
- `addr_i` in 32: CPU address.
- `data_i` in 32: CPU write data, already byte-swapped to normal order.
- `data_w_i` in 1: CPU write strobe (any byte-lane enable set).
- `data_o` out 32: registered read data.
- `data_access_o` out 1: combinational, 1 when `addr_i[31:24]==BASE_TAG`.
- `m_axis_tvalid_o` out 1: stream valid.
- `m_axis_tdata_o` out 8: stream data.
- `m_axis_tready_i` in 1: stream ready.

## Operation
- **Register map** (offset `addr_i[3:2]`):
  - 0 DATA: write pushes `data_i[7:0]`; reads 0.
  - 1 STATUS: read only, with these bits:
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bits[15:8] level
    - other bits 0
  - 2 CTRL: write bit0=1 flushes the FIFO; write bit1=1 clears overflow; reads 0.
  - 3: reserved; reads 0, writes ignored.
- **Push**: `data_access_o && data_w_i && offset==0`, evaluated every cycle the condition holds. The CPU has no stall, so a push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- **Pop**: `m_axis_tvalid_o && m_axis_tready_i`.
- **Push and pop in the same cycle** with the FIFO not full: both take effect and the level is unchanged.
- **FIFO mechanics**:
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - Level is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
  - full = (level==DEPTH); empty = (level==0).
- **Stream output**: `m_axis_tvalid_o` = !empty, taken from the registered level. `m_axis_tdata_o` = mem[rd_ptr].
  - Once valid is high, tdata stays stable until accepted. Valid never drops without a handshake, except on flush or reset.
- **Flush**: at the next edge, pointers and level go to 0 and any push in the same cycle is discarded. Overflow is unaffected unless bit1 is also set.
- **Overflow**: setting takes priority over clearing when both happen in the same cycle.
- **Reads**: `data_o` is loaded every cycle with the selected register value for the current `addr_i`, or 0 when not selected. It is valid the cycle after the address, matching the top-level `*_dly` read mux.

## Timing
- **Reset values**: `data_o`=0, `m_axis_tvalid_o`=0, `m_axis_tdata_o`=mem[0] (don't-care), level=0, pointers=0, overflow=0. FIFO memory is not reset.
- **Reset mid-operation**: the FIFO empties and valid drops at the reset edge; any in-flight beat is lost.
- **Push-to-valid latency**: push at edge N gives `m_axis_tvalid_o`=1 after edge N, i.e. one cycle. There is no bypass.
- **Throughput**: one beat per cycle while ready is held and the FIFO is non-empty.
- **STATUS timing**: reflects state after the previous edge, so a read issued in the push cycle shows the pre-push level.
- **Combinational paths**: `data_access_o` is combinational from `addr_i`. There is no combinational path from `m_axis_tready_i` to any output other than through registers.

## Structure
- Package `axis_tx_pkg` holds:
  - offset constants `TX_DATA`=2'd0, `TX_STATUS`=2'd1, `TX_CTRL`=2'd2
  - status bit indices `ST_FULL`=0, `ST_EMPTY`=1, `ST_OVF`=2, `ST_LVL_LSB`=8
  - CTRL bit indices `CT_FLUSH`=0, `CT_OVF_CLR`=1
- Sub-module `axis_sync_fifo` (parameters WIDTH, DEPTH): push, pop, flush, full, empty, level, head data.
- The top-level block contains the address decode, register read mux and overflow flag.

## Test plan
- **Single byte**:
  - Stimulus: write 0x000000A5 to offset 0, ready=1.
  - Required: tvalid high exactly one cycle later with tdata=0xA5. Accepted that cycle, then valid=0. STATUS then reads 0x00000002.
- **Fill and overflow**:
  - Stimulus: ready=0; write 0x01..0x09 (DEPTH=8).
  - Required: STATUS=0x00000805 (level 8, full, overflow). Raising ready drains 0x01..0x08 in order, 8 consecutive beats, and 0x09 is never seen.
- **Backpressure stability**:
  - Stimulus: push 0x11 and 0x22; toggle ready 1,0,0,1.
  - Required: tdata holds 0x22 during the low-ready cycles; exactly 2 handshakes occur.
- **Simultaneous push/pop at level 3 and pointer wrap**:
  - Stimulus: push while accepting; continue for 20 bytes across the wrap.
  - Required: level stays 3 and output order is preserved.
- **Flush and clear**:
  - Stimulus: with 5 queued, write CTRL=0x1.
  - Required: valid=0 next cycle and STATUS level=0. Then write CTRL=0x2; the overflow bit clears.
- **Reset mid-stream**:
  - Stimulus: assert `rst_i` for one cycle with 4 queued and ready=0.
  - Required: valid=0 and `data_o`=0 after the edge. A subsequent push of 0x5A emerges first.

Source files
------------

// File: rtl/axis_tx_if_pkg.sv
// axis_tx_pkg: register offsets, status/ctrl bit positions and status word packing for axis_tx_if
package axis_tx_pkg;
  localparam logic [1:0] TX_DATA = 2'd0;
  localparam logic [1:0] TX_STATUS = 2'd1;
  localparam logic [1:0] TX_CTRL = 2'd2;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF = 2;
  localparam int ST_LVL_LSB = 8;
  localparam int CT_FLUSH = 0;
  localparam int CT_OVF_CLR = 1;
  // level wider than the 8-bit field (DEPTH=256) wraps to 0; full still reports it
  function automatic logic [31:0] status_word(input logic full, input logic empty, input logic ovf, input logic [31:0] lvl);
    return ((lvl << ST_LVL_LSB) & 32'h0000_FF00) | (32'(ovf) << ST_OVF) | (32'(empty) << ST_EMPTY) | (32'(full) << ST_FULL);
  endfunction
endpackage

// File: rtl/axis_tx_if_if.sv
// axis_tx_if_if: CPU register window plus 8-bit AXI-stream master signals
interface axis_tx_if_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic data_w_i;
  logic [31:0] data_o;
  logic data_access_o;
  logic m_axis_tvalid_o;
  logic [7:0] m_axis_tdata_o;
  logic m_axis_tready_i;
  modport master (output addr_i, data_i, data_w_i, m_axis_tready_i, input data_o, data_access_o, m_axis_tvalid_o, m_axis_tdata_o);
  modport slave (input addr_i, data_i, data_w_i, m_axis_tready_i, output data_o, data_access_o, m_axis_tvalid_o, m_axis_tdata_o);
endinterface

// File: rtl/axis_tx_if_fifo.sv
// axis_sync_fifo: power-of-two synchronous FIFO with flush, level and registered-memory head
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic full_o,
  output logic empty_o,
  output logic [AW:0] level_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic wr_en, rd_en;
  always_comb begin
    wr_en = push_i && !full_o && !flush_i;
    rd_en = pop_i && !empty_o && !flush_i;
    wr_d = flush_i ? '0 : wr_q + AW'(wr_en);
    rd_d = flush_i ? '0 : rd_q + AW'(rd_en);
    lvl_d = flush_i ? '0 : lvl_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end
  assign full_o = lvl_q == (AW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
  assign head_o = mem_q[rd_q];
endmodule

// File: rtl/axis_tx_if.sv
// axis_tx_if: CPU byte-write window buffered into an 8-bit AXI-stream master
module axis_tx_if
  import axis_tx_pkg::*;
#(
  parameter logic [7:0] BASE_TAG = 8'hE2,
  parameter int DEPTH = 8
) (
  input logic clk_i,
  input logic rst_i,
  axis_tx_if_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic sel, wr, push, flush, ovf_clr, full, empty;
  logic [1:0] off;
  logic [AW:0] level;
  logic ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  always_comb begin
    sel = bus.addr_i[31:24] == BASE_TAG;
    off = bus.addr_i[3:2];
    wr = sel && bus.data_w_i;
    push = wr && off == TX_DATA;
    flush = wr && off == TX_CTRL && bus.data_i[CT_FLUSH];
    ovf_clr = wr && off == TX_CTRL && bus.data_i[CT_OVF_CLR];
    ovf_d = (push && full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    rdata_d = (sel && off == TX_STATUS) ? status_word(full, empty, ovf_q, 32'(level)) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      rdata_q <= rdata_d;
    end
  end
  axis_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(push),
    .pop_i(bus.m_axis_tvalid_o && bus.m_axis_tready_i),
    .flush_i(flush),
    .din_i(bus.data_i[7:0]),
    .full_o(full),
    .empty_o(empty),
    .level_o(level),
    .head_o(bus.m_axis_tdata_o)
  );
  assign bus.data_access_o = sel;
  assign bus.m_axis_tvalid_o = !empty;
  assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_axis_tx_if.sv
// tb_axis_tx_if: queue-based reference model checked every cycle, plus directed literal checks
module tb_axis_tx_if;
  localparam int DEPTH = 8;
  localparam logic [7:0] TAG = 8'hE2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit started = 0;
  logic [7:0] q[$];
  logic [7:0] dut_acc[$];
  bit ovf = 0;
  logic [31:0] exp_rd = '0;
  bit m_sel, m_wr, m_push, m_flush, m_clr, m_full;
  logic [1:0] m_off;

  axis_tx_if_if bus();
  axis_tx_if #(.BASE_TAG(TAG), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] st_model();
    int n = q.size();
    return 32'((n == DEPTH ? 1 : 0) + (n == 0 ? 2 : 0) + (ovf ? 4 : 0) + n * 256);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive_raw(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    @(posedge clk);
    #2;
    bus.addr_i = a;
    bus.data_i = d;
    bus.data_w_i = w;
    bus.m_axis_tready_i = r;
  endtask

  task automatic drive(input logic [1:0] off, input logic [31:0] d, input logic w, input logic r);
    drive_raw({TAG, 20'h0, off, 2'b00}, d, w, r);
  endtask

  // reference model: sees the inputs the DUT samples at each rising edge
  initial forever begin
    @(posedge clk);
    m_sel = bus.addr_i[31:24] == TAG;
    m_off = bus.addr_i[3:2];
    m_wr = m_sel && bus.data_w_i;
    if (bus.m_axis_tvalid_o === 1'b1 && bus.m_axis_tready_i) dut_acc.push_back(bus.m_axis_tdata_o);
    if (rst) begin
      q.delete();
      ovf = 0;
      exp_rd = '0;
    end else begin
      exp_rd = (m_sel && m_off == 2'd1) ? st_model() : 32'h0;
      m_full = q.size() == DEPTH;
      m_push = m_wr && m_off == 2'd0;
      m_flush = m_wr && m_off == 2'd2 && bus.data_i[0];
      m_clr = m_wr && m_off == 2'd2 && bus.data_i[1];
      if (m_flush) q.delete();
      else begin
        if (q.size() > 0 && bus.m_axis_tready_i) void'(q.pop_front());
        if (m_push && !m_full) q.push_back(bus.data_i[7:0]);
      end
      if (m_push && m_full) ovf = 1;
      else if (m_clr) ovf = 0;
    end
    started = 1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("access", 32'(bus.data_access_o), 32'(bus.addr_i[31:24] == TAG));
      chk("tvalid", 32'(bus.m_axis_tvalid_o), 32'(q.size() > 0));
      if (q.size() > 0) chk("tdata", 32'(bus.m_axis_tdata_o), 32'(q[0]));
      chk("data_o", bus.data_o, exp_rd);
    end
  end

  initial begin
    logic [31:0] r, d, a;
    logic [1:0] off;
    logic [7:0] tag;
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.data_w_i = 1'b0;
    bus.m_axis_tready_i = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid_o), 32'd0);
    chk("rst_data_o", bus.data_o, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(2'd0, 32'h0000_00A5, 1'b1, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    chk("s1_valid", 32'(bus.m_axis_tvalid_o), 32'd1);
    chk("s1_data", 32'(bus.m_axis_tdata_o), 32'h A5);
    drive(2'd1, 32'h0, 1'b0, 1'b1);
    chk("s1_drained", 32'(bus.m_axis_tvalid_o), 32'd0);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    chk("s1_status", bus.data_o, 32'h0000_0002);
    for (int i = 1; i <= 9; i++) drive(2'd0, 32'(i), 1'b1, 1'b0);
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s2_status", bus.data_o, 32'h0000_0805);
    dut_acc.delete();
    repeat (8) drive(2'd3, 32'h0, 1'b0, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s2_beats", 32'(dut_acc.size()), 32'd8);
    for (int i = 0; i < 8 && i < dut_acc.size(); i++) chk("s2_order", 32'(dut_acc[i]), 32'(i + 1));
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    chk("s2_no_09", 32'(dut_acc.size()), 32'd8);
    for (int i = 0; i < 5; i++) drive(2'd0, 32'h40 + 32'(i), 1'b1, 1'b0);
    drive(2'd2, 32'h1, 1'b1, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s5_flush_valid", 32'(bus.m_axis_tvalid_o), 32'd0);
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s5_status_flushed", bus.data_o, 32'h0000_0006);
    drive(2'd2, 32'h2, 1'b1, 1'b0);
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s5_status_cleared", bus.data_o, 32'h0000_0002);
    dut_acc.delete();
    drive(2'd0, 32'h11, 1'b1, 1'b0);
    drive(2'd0, 32'h22, 1'b1, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s3_hold_a", 32'(bus.m_axis_tdata_o), 32'h22);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s3_hold_b", 32'(bus.m_axis_tdata_o), 32'h22);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s3_handshakes", 32'(dut_acc.size()), 32'd2);
    if (dut_acc.size() == 2) begin
      chk("s3_first", 32'(dut_acc[0]), 32'h11);
      chk("s3_second", 32'(dut_acc[1]), 32'h22);
    end
    dut_acc.delete();
    for (int i = 0; i < 3; i++) drive(2'd0, 32'h30 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(2'd0, 32'h33 + 32'(i), 1'b1, 1'b1);
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    drive(2'd3, 32'h0, 1'b0, 1'b0);
    chk("s4_status", bus.data_o, 32'h0000_0300);
    chk("s4_beats", 32'(dut_acc.size()), 32'd20);
    for (int i = 0; i < 20 && i < dut_acc.size(); i++) chk("s4_order", 32'(dut_acc[i]), 32'h30 + 32'(i));
    drive(2'd0, 32'h47, 1'b1, 1'b0);
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(2'd1, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("s6_valid", 32'(bus.m_axis_tvalid_o), 32'd0);
    chk("s6_data_o", bus.data_o, 32'd0);
    drive(2'd0, 32'h5A, 1'b1, 1'b1);
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    chk("s6_valid_after", 32'(bus.m_axis_tvalid_o), 32'd1);
    chk("s6_first", 32'(bus.m_axis_tdata_o), 32'h5A);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      d = $urandom();
      off = 2'($urandom_range(0, 3));
      tag = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : TAG;
      if (off == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      a = {tag, r[23:4], off, r[1:0]};
      drive_raw(a, d, 1'($urandom_range(0, 1)), ((i / 200) % 2 == 0) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0));
      rst = ($urandom_range(0, 299) == 0);
    end
    drive(2'd3, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (3) drive(2'd3, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
